// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between the requesting agents and rr_grant_ctrl.
// master: the requester side (drives enable/req, observes the grant).
// slave:  the arbiter side (observes requests, drives the grant outputs).
interface rr_grant_ctrl_if;

    logic       enable;     // global arbitration enable
    logic [3:0] req;        // level-sensitive request, bit i = requester i
    logic [3:0] gnt;        // one-hot grant, all-zero when idle
    logic [1:0] gnt_idx;    // binary index of the current/last grant
    logic       gnt_valid;  // gnt is non-zero
    logic       timeout;    // one-cycle pulse on a forced release

    modport master (
        output enable,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  enable,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/rr_grant_ctrl.sv
// Four-way round-robin arbiter with a bounded hold time.
// A granted requester keeps the grant while its request stays high, for at
// most MAX_HOLD cycles. On release the next winner takes over on the same
// edge (no gap). On a forced release the grant drops, timeout pulses for one
// cycle (the COOL cycle), one IDLE cycle follows, and arbitration resumes with
// the timed-out requester at lowest priority.
module rr_grant_ctrl #(
    parameter int MAX_HOLD = 8,     // 1..255
    parameter int CNT_W    = 8      // 2**CNT_W > MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_grant_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    // Counter value at which a still-held grant is force-released.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic [1:0]       last_reg;
    logic [3:0]       gnt_reg;
    logic [1:0]       gnt_idx_reg;
    logic             gnt_valid_reg;
    logic             timeout_reg;

    logic [3:0]       rot_req;
    logic [1:0]       rot_sel;
    logic [1:0]       win_idx;
    logic [3:0]       win_onehot;
    logic             any_req;
    logic             own_req;

    // Requests rotated so that bit k is requester (last+1+k) mod 4; bit 0 is
    // therefore the highest-priority candidate and bit 3 is last itself.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = bus.req[last_reg + 2'(gi + 1)];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the winner's offset from last+1.
    always_comb begin
        rot_sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                rot_sel = 2'(k);
            end
        end
    end

    assign win_idx = last_reg + rot_sel + 2'd1;
    assign any_req = |bus.req;
    assign own_req = bus.req[gnt_idx_reg];

    // Decode the winner index into the one-hot grant pattern.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign win_onehot[gi] = (win_idx == 2'(gi));
        end
    endgenerate

    // Arbitration FSM; every output is a register so gnt, gnt_idx and
    // gnt_valid always change together on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            hold_cnt_reg  <= '0;
            last_reg      <= 2'd3;
            gnt_reg       <= 4'b0000;
            gnt_idx_reg   <= 2'd0;
            gnt_valid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            if (!bus.enable) begin
                // Disable preempts everything, including a pending timeout;
                // last and gnt_idx are kept so fairness survives the pause.
                state_reg     <= ST_IDLE;
                hold_cnt_reg  <= '0;
                gnt_reg       <= 4'b0000;
                gnt_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (any_req) begin
                            state_reg     <= ST_GRANT;
                            hold_cnt_reg  <= '0;
                            gnt_reg       <= win_onehot;
                            gnt_idx_reg   <= win_idx;
                            gnt_valid_reg <= 1'b1;
                            last_reg      <= win_idx;
                        end
                    end

                    ST_GRANT: begin
                        if (!own_req) begin
                            // Release takes precedence over a same-cycle
                            // timeout. The holder's own request is low, so
                            // the winner is always a different requester.
                            hold_cnt_reg <= '0;
                            if (any_req) begin
                                gnt_reg       <= win_onehot;
                                gnt_idx_reg   <= win_idx;
                                gnt_valid_reg <= 1'b1;
                                last_reg      <= win_idx;
                            end else begin
                                state_reg     <= ST_IDLE;
                                gnt_reg       <= 4'b0000;
                                gnt_valid_reg <= 1'b0;
                            end
                        end else if (hold_cnt_reg == HOLD_LAST) begin
                            // Forced release; last stays on the holder so it
                            // drops to lowest priority for the next round.
                            state_reg     <= ST_COOL;
                            hold_cnt_reg  <= '0;
                            gnt_reg       <= 4'b0000;
                            gnt_valid_reg <= 1'b0;
                            timeout_reg   <= 1'b1;
                        end else begin
                            // Never passes HOLD_LAST, so it cannot wrap.
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end

                    ST_COOL: begin
                        state_reg <= ST_IDLE;
                    end

                    default: begin
                        state_reg     <= ST_IDLE;
                        hold_cnt_reg  <= '0;
                        gnt_reg       <= 4'b0000;
                        gnt_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_idx   = gnt_idx_reg;
    assign bus.gnt_valid = gnt_valid_reg;
    assign bus.timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed and constrained-random checks for rr_grant_ctrl with MAX_HOLD=8.
module tb_rr_grant_ctrl;

    localparam int MAX_HOLD = 8;
    localparam int BOUND    = 4 * (MAX_HOLD + 2);
    localparam int N_RAND   = 10000;
    localparam int N_RAND_A = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    rr_grant_ctrl_if bus_if ();

    rr_grant_ctrl #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                              input logic v, input logic t);
        $display("%-10s req=%b en=%b | gnt=%b idx=%0d valid=%b timeout=%b",
                 tag, bus_if.req, bus_if.enable, bus_if.gnt, bus_if.gnt_idx,
                 bus_if.gnt_valid, bus_if.timeout);
        check_val({tag, ".gnt"},       32'(bus_if.gnt),       32'(g));
        check_val({tag, ".gnt_idx"},   32'(bus_if.gnt_idx),   32'(idx));
        check_val({tag, ".gnt_valid"}, 32'(bus_if.gnt_valid), 32'(v));
        check_val({tag, ".timeout"},   32'(bus_if.timeout),   32'(t));
    endtask

    logic [3:0] req_v;
    logic       en_v;
    logic [3:0] prev_gnt;
    int         run_len;
    int         wait_cnt [4];

    initial begin
        bus_if.enable = 1'b0;
        bus_if.req    = 4'b0000;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // All four request, each drops on its grant: direct handoff 0,1,2,3
        bus_if.enable = 1'b1;
        bus_if.req    = 4'b1111;
        step();
        expect_out("rr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus_if.req = 4'b1110;
        step();
        expect_out("rr1", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus_if.req = 4'b1100;
        step();
        expect_out("rr2", 4'b0100, 2'd2, 1'b1, 1'b0);
        bus_if.req = 4'b1000;
        step();
        expect_out("rr3", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus_if.req = 4'b0000;
        step();
        expect_out("rr_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Sole requester 2 held: 8 grant cycles, timeout, idle, re-grant
        bus_if.req = 4'b0100;
        step();
        for (int i = 0; i < MAX_HOLD; i++) begin
            expect_out("hold2", 4'b0100, 2'd2, 1'b1, 1'b0);
            step();
        end
        expect_out("tmo2", 4'b0000, 2'd2, 1'b0, 1'b1);
        step();
        expect_out("cool2", 4'b0000, 2'd2, 1'b0, 1'b0);
        step();
        expect_out("regrant2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Requester 0 joins; after 2 times out, 0 wins instead of 2
        bus_if.req = 4'b0101;
        for (int i = 0; i < MAX_HOLD; i++) begin
            expect_out("hold2b", 4'b0100, 2'd2, 1'b1, 1'b0);
            step();
        end
        expect_out("tmo2b", 4'b0000, 2'd2, 1'b0, 1'b1);
        step();
        expect_out("cool2b", 4'b0000, 2'd2, 1'b0, 1'b0);
        step();
        expect_out("after_tmo", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus_if.req = 4'b0000;
        step();
        expect_out("idle_a", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Enable drop mid-grant, then re-enable with wrap-around priority
        bus_if.req = 4'b0010;
        step();
        expect_out("gnt1", 4'b0010, 2'd1, 1'b1, 1'b0);
        bus_if.enable = 1'b0;
        step();
        expect_out("disabled", 4'b0000, 2'd1, 1'b0, 1'b0);
        bus_if.enable = 1'b1;
        bus_if.req    = 4'b0011;
        step();
        expect_out("reenable", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus_if.req = 4'b0000;
        step();
        expect_out("idle_b", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset mid-grant, then requester 0 wins again from last=3
        bus_if.req = 4'b1000;
        step();
        expect_out("gnt3", 4'b1000, 2'd3, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        expect_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus_if.req = 4'b1001;
        step();
        expect_out("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Release at the timeout cycle: handoff to 3, no timeout pulse
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            step();
            expect_out("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        bus_if.req = 4'b1000;
        step();
        expect_out("rel_vs_tmo", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus_if.req = 4'b0000;
        step();
        expect_out("idle_c", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Random phase: invariants throughout, starvation bound with enable=1
        req_v    = 4'b0000;
        prev_gnt = 4'b0000;
        run_len  = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < N_RAND; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) req_v[i] = ~req_v[i];
            end
            en_v = (cyc >= N_RAND_A) ? 1'b1 : ($urandom_range(15) != 0);
            bus_if.req    = req_v;
            bus_if.enable = en_v;
            step();

            check_val("onehot", 32'($onehot0(bus_if.gnt)), 32'd1);
            check_val("valid_vs_gnt", 32'(bus_if.gnt_valid), 32'(|bus_if.gnt));
            if (bus_if.gnt_valid)
                check_val("gnt_vs_idx", 32'(bus_if.gnt), 32'd1 << bus_if.gnt_idx);
            if (bus_if.timeout) begin
                check_val("gnt_on_tmo", 32'(bus_if.gnt), 32'd0);
                check_val("run_at_tmo", 32'(run_len), 32'(MAX_HOLD));
            end

            if (bus_if.gnt_valid && bus_if.gnt == prev_gnt) run_len++;
            else if (bus_if.gnt_valid) run_len = 1;
            else run_len = 0;
            prev_gnt = bus_if.gnt;
            check_val("hold_len", 32'(run_len <= MAX_HOLD), 32'd1);

            if (cyc >= N_RAND_A) begin
                for (int i = 0; i < 4; i++) begin
                    if (req_v[i] && !bus_if.gnt[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    check_val("starve", 32'(wait_cnt[i] <= BOUND), 32'd1);
                end
            end
        end
        $display("random    %0d cycles done", N_RAND);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
